riscv_mc_control: RTL and testbench
===================================

// Module: riscv_mc_control
// PURPOSE
//  Multicycle control FSM for the RV32I core; it is the encoder side of the ALU's 4-bit ALUOp interface.
//  Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath control signals.
//  It derives ALUOp and the operand selects from the IR, then uses ALU flags to resolve branches.
// PARAMETERS
//  RESET_STATE  3'd0  encoding loaded on reset (FETCH); any other value is unsupported
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   synchronous, active-high reset
//  instr       in   32  IR contents, valid from DECODE onward
//  imem_ack    in   1   instruction word valid this cycle
//  dmem_ack    in   1   data access complete this cycle
//  alu_zero    in   1   ALURes == 0
//  alu_lsb     in   1   ALURes[0] (SLT/SLTU result)
//  imem_req    out  1   fetch request, held until imem_ack
//  dmem_req    out  1   data request, held until dmem_ack
//  dmem_we     out  1   store when 1, load when 0 (valid with dmem_req)
//  ir_write    out  1   latch instr into IR (pulse)
//  ALUOp       out  4   ALU function code
//  alu_src_a   out  1   0=rs1, 1=PC
//  alu_src_b   out  1   0=rs2, 1=immediate
//  imm_sel     out  3   0=I 1=S 2=B 3=U 4=J
//  result_src  out  2   0=ALU result 1=load data 2=PC+4
//  reg_write   out  1   regfile write strobe (pulse)
//  pc_write    out  1   PC update strobe (pulse)
//  pc_src      out  2   0=PC+4 1=PC+imm 2={ALU[31:1],1'b0}
//  illegal     out  1   unsupported opcode/funct decoded
// BEHAVIOUR
//  - All state and outputs are synchronous to clk. While rst=1: state=FETCH, taken=0, illegal=0, every strobe and req=0, ALUOp=4'b0000, all selects=0.
//  - A reset mid-instruction aborts it. Any outstanding req drops in the same cycle, and no reg_write/pc_write is issued.
//  - FETCH: imem_req=1 until imem_ack. On the ack cycle, ir_write=1 and the FSM goes to DECODE. A stalled ack holds the state.
//  - DECODE (1 cycle): classifies opcode and checks funct3/funct7 legality, then goes to EXEC, or to TRAP when illegal.
//  - EXEC (1 cycle): drives ALUOp, src and imm_sel; samples taken = branch condition at the clock edge.
//    - Loads and stores go to MEM; all other classes go to WB.
//  - MEM: dmem_req=1 (dmem_we=1 for stores) until dmem_ack, then WB.
//  - WB (1 cycle): pc_write=1 and reg_write=1 for every class except STORE and BRANCH. Next state is FETCH.
//  - Zero-wait latency: ALU/LUI/AUIPC/JAL/JALR/branch = 4 cycles; load/store = 5 cycles.
//  - ALUOp map:
//    - R-type: {f7[5],f3}. OP-IMM: {f3==101 ? f7[5] : 0, f3}.
//    - LUI: 1001 with src_b=imm. AUIPC: 0000 with src_a=PC.
//    - LOAD/STORE/JALR: 0000.
//    - BEQ/BNE: 1000. BLT/BGE: 0010. BLTU/BGEU: 0011.
//  - Branch taken conditions:
//    - BEQ = zero; BNE = !zero.
//    - BLT/BLTU = lsb; BGE/BGEU = !lsb.
//    - pc_src=1 when taken, else 0.
//  - Jumps: JAL uses pc_src=1; JALR uses pc_src=2. Both use result_src=2.
//  - Illegal encodings:
//    - unknown opcode;
//    - R-type f7 not in {0x00,0x20}, or f7=0x20 with f3 not in {000,101};
//    - SLLI/SRLI f7 != 0; SRAI f7 != 0x20;
//    - branch f3 in {010,011}.
//  - imem_ack arriving outside FETCH and dmem_ack arriving outside MEM are ignored.
// CONFIGURATION
//  RISCV_MC_ILLEGAL_TRAP_EN
//  - Defined: TRAP holds illegal=1 with all strobes 0, and the FSM stays in TRAP until rst.
//  - Undefined: an illegal instruction executes as a NOP. DECODE -> WB with illegal=1 for that WB cycle only, pc_write=1, pc_src=0, reg_write=0.
// TESTING
//  - Reset: rst=1 for 3 clk, then 0 -> all outputs 0 during reset; imem_req=1 on the first cycle after release.
//  - ADD x3,x1,x2 (0x002081B3), imem_ack immediate -> ALUOp=0000 in EXEC; reg_write, pc_write, pc_src=0 in cycle 4.
//  - SRAI x5,x5,3 (0x4032D293) -> ALUOp=1101, alu_src_b=1, imm_sel=0; SRLI 0x0032D293 -> ALUOp=0101.
//  - LW x4,8(x1) (0x0080A203), dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0, result_src=1, reg_write in WB.
//  - BLT (0x0020C463) with alu_lsb=1 -> ALUOp=0010, pc_src=1; with alu_lsb=0 -> pc_src=0; reg_write=0 in both cases.
//  - Opcode 0x0000007F -> illegal=1; trap held (EN defined) or PC+4 advance with no reg_write (undefined). rst in MEM drops dmem_req the same cycle.

Source files
------------

// File: rtl/riscv_mc_control.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, ALUOp encoding and branch resolution.
// Optional build macro RISCV_MC_ILLEGAL_TRAP_EN: illegal encodings lock the FSM in TRAP until rst.
module riscv_mc_control #(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        alu_zero,
    input  logic        alu_lsb,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_write,
    output logic [3:0]  ALUOp,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic [2:0]  imm_sel,
    output logic [1:0]  result_src,
    output logic        reg_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        illegal
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    state_t     state, state_n;
    logic       taken;
    logic       ill_q;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_load, is_store, is_branch, is_jal, is_jalr;
    logic       dec_illegal;
    logic [3:0] dec_aluop;
    logic       dec_src_a, dec_src_b;
    logic [2:0] dec_imm;
    logic       br_cond;
    logic       unused_instr_bits;

    assign opcode    = instr[6:0];
    assign f3        = instr[14:12];
    assign f7        = instr[31:25];
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);

    // Register indices and immediate bits belong to the datapath, not to control.
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    always_comb begin
        dec_illegal = 1'b0;
        dec_aluop   = 4'b0000;
        dec_src_a   = 1'b0;
        dec_src_b   = 1'b0;
        dec_imm     = IMM_I;
        case (opcode)
            OPC_OP: begin
                dec_aluop = {f7[5], f3};
                if (!((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)))))
                    dec_illegal = 1'b1;
            end
            OPC_OPIMM: begin
                dec_aluop = {(f3 == 3'b101) & f7[5], f3};
                dec_src_b = 1'b1;
                if ((f3 == 3'b001) && (f7 != 7'h00))
                    dec_illegal = 1'b1;
                if ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20))
                    dec_illegal = 1'b1;
            end
            OPC_LUI: begin
                dec_aluop = 4'b1001;
                dec_src_b = 1'b1;
                dec_imm   = IMM_U;
            end
            OPC_AUIPC: begin
                dec_src_a = 1'b1;
                dec_src_b = 1'b1;
                dec_imm   = IMM_U;
            end
            OPC_LOAD: begin
                dec_src_b = 1'b1;
            end
            OPC_STORE: begin
                dec_src_b = 1'b1;
                dec_imm   = IMM_S;
            end
            OPC_JAL: begin
                dec_src_a = 1'b1;
                dec_src_b = 1'b1;
                dec_imm   = IMM_J;
            end
            OPC_JALR: begin
                dec_src_b = 1'b1;
            end
            OPC_BRANCH: begin
                dec_imm = IMM_B;
                case (f3)
                    3'b000, 3'b001: dec_aluop = 4'b1000;
                    3'b100, 3'b101: dec_aluop = 4'b0010;
                    3'b110, 3'b111: dec_aluop = 4'b0011;
                    default:        dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        case (f3)
            3'b000:         br_cond = alu_zero;
            3'b001:         br_cond = !alu_zero;
            3'b100, 3'b110: br_cond = alu_lsb;
            3'b101, 3'b111: br_cond = !alu_lsb;
            default:        br_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= state_t'(RESET_STATE);
            taken <= 1'b0;
            ill_q <= 1'b0;
        end else begin
            state <= state_n;
            if (state == EXEC)
                taken <= br_cond;
            if (state == DECODE)
                ill_q <= dec_illegal;
        end
    end

    always_comb begin
        state_n    = state;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_write   = 1'b0;
        ALUOp      = 4'b0000;
        alu_src_a  = 1'b0;
        alu_src_b  = 1'b0;
        imm_sel    = IMM_I;
        result_src = 2'd0;
        reg_write  = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_write = 1'b1;
                    state_n  = DECODE;
                end
            end
            DECODE: begin
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
                state_n = dec_illegal ? TRAP : EXEC;
`else
                state_n = dec_illegal ? WB : EXEC;
`endif
            end
            EXEC: begin
                ALUOp     = dec_aluop;
                alu_src_a = dec_src_a;
                alu_src_b = dec_src_b;
                imm_sel   = dec_imm;
                state_n   = (is_load || is_store) ? MEM : WB;
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ack)
                    state_n = WB;
            end
            WB: begin
                pc_write = 1'b1;
                state_n  = FETCH;
                if (ill_q) begin
                    illegal = 1'b1;
                end else begin
                    reg_write = !(is_store || is_branch);
                    if (is_load)
                        result_src = 2'd1;
                    else if (is_jal || is_jalr)
                        result_src = 2'd2;
                    if (is_jal || (is_branch && taken))
                        pc_src = 2'd1;
                    else if (is_jalr)
                        pc_src = 2'd2;
                end
            end
            TRAP: begin
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
                illegal = 1'b1;
                state_n = TRAP;
`else
                state_n = FETCH;
`endif
            end
            default: state_n = FETCH;
        endcase

        // Reset must silence every request and strobe within the cycle it is asserted.
        if (rst) begin
            imem_req   = 1'b0;
            dmem_req   = 1'b0;
            dmem_we    = 1'b0;
            ir_write   = 1'b0;
            ALUOp      = 4'b0000;
            alu_src_a  = 1'b0;
            alu_src_b  = 1'b0;
            imm_sel    = IMM_I;
            result_src = 2'd0;
            reg_write  = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'd0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_mc_control.sv
// Self-checking bench for riscv_mc_control: per-instruction expected cycle traces from an ISA-level model.
// Honours RISCV_MC_ILLEGAL_TRAP_EN the same way as the design.
module tb_riscv_mc_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        imem_ack, dmem_ack, alu_zero, alu_lsb;
    logic        imem_req, dmem_req, dmem_we, ir_write;
    logic [3:0]  ALUOp;
    logic        alu_src_a, alu_src_b;
    logic [2:0]  imm_sel;
    logic [1:0]  result_src;
    logic        reg_write, pc_write;
    logic [1:0]  pc_src;
    logic        illegal;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    riscv_mc_control dut (
        .clk(clk), .rst(rst), .instr(instr),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .alu_zero(alu_zero), .alu_lsb(alu_lsb),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_write(ir_write), .ALUOp(ALUOp),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_sel(imm_sel),
        .result_src(result_src), .reg_write(reg_write), .pc_write(pc_write),
        .pc_src(pc_src), .illegal(illegal)
    );

    // Expected architectural behaviour of one instruction word.
    typedef struct {
        logic       ill, mem, st;
        logic [3:0] op;
        logic       sa, sb;
        logic [2:0] imm;
        logic       c_op, c_sa, c_sb, c_imm;
        logic       rw;
        logic [1:0] rs;
        int         jmp;
    } ref_t;

    typedef struct {
        logic        ia, da, z, l;
        logic [31:0] ins;
        logic [19:0] e, m;
        int          ph;
    } cyc_t;

    cyc_t trace[$];

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [19:0] pk(logic ireq, logic irw, logic dreq, logic dwe, logic rw,
                                       logic pw, logic ill, logic [3:0] op, logic sa, logic sb,
                                       logic [2:0] imm, logic [1:0] rs, logic [1:0] ps);
        return {ireq, irw, dreq, dwe, rw, pw, ill, op, sa, sb, imm, rs, ps};
    endfunction

    function automatic logic [19:0] observe();
        return {imem_req, ir_write, dmem_req, dmem_we, reg_write, pc_write, illegal,
                ALUOp, alu_src_a, alu_src_b, imm_sel, result_src, pc_src};
    endfunction

    function automatic string ph_name(int ph);
        case (ph)
            0: return "fetch_wait";
            1: return "fetch_ack";
            2: return "decode";
            3: return "exec";
            4: return "mem";
            5: return "writeback";
            6: return "trap";
            default: return "next_fetch";
        endcase
    endfunction

    function automatic cyc_t mk(logic ia, logic da, logic z, logic l, logic [31:0] ins,
                                logic [19:0] e, logic [19:0] m, int ph);
        cyc_t c;
        c.ia = ia; c.da = da; c.z = z; c.l = l; c.ins = ins; c.e = e; c.m = m; c.ph = ph;
        return c;
    endfunction

    function automatic logic branch_taken(logic [2:0] f3, logic z, logic l);
        if (f3 == 3'd0) return z;
        if (f3 == 3'd1) return !z;
        if (f3 == 3'd4 || f3 == 3'd6) return l;
        return !l;
    endfunction

    function automatic ref_t ref_decode(logic [31:0] ins);
        ref_t r;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        r.ill = 1'b0; r.mem = 1'b0; r.st = 1'b0; r.op = 4'd0; r.sa = 1'b0; r.sb = 1'b0;
        r.imm = 3'd0; r.c_op = 1'b1; r.c_sa = 1'b1; r.c_sb = 1'b1; r.c_imm = 1'b1;
        r.rw = 1'b1; r.rs = 2'd0; r.jmp = 0;
        case (opc)
            7'h33: begin
                r.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
                r.op = {f7[5], f3}; r.c_imm = 1'b0;
            end
            7'h13: begin
                r.ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
                r.op = {(f3 == 3'd5) ? f7[5] : 1'b0, f3}; r.sb = 1'b1;
            end
            7'h37: begin r.op = 4'b1001; r.sb = 1'b1; r.imm = 3'd3; r.c_sa = 1'b0; end
            7'h17: begin r.sa = 1'b1; r.sb = 1'b1; r.imm = 3'd3; end
            7'h03: begin r.sb = 1'b1; r.mem = 1'b1; r.rs = 2'd1; end
            7'h23: begin r.sb = 1'b1; r.imm = 3'd1; r.mem = 1'b1; r.st = 1'b1; r.rw = 1'b0; end
            7'h6F: begin r.c_op = 1'b0; r.c_sa = 1'b0; r.c_sb = 1'b0; r.c_imm = 1'b0; r.rs = 2'd2; r.jmp = 1; end
            7'h67: begin r.sb = 1'b1; r.rs = 2'd2; r.jmp = 2; end
            7'h63: begin
                r.ill = (f3 == 3'd2 || f3 == 3'd3);
                r.op = (f3 < 3'd4) ? 4'b1000 : ((f3 < 3'd6) ? 4'b0010 : 4'b0011);
                r.imm = 3'd2; r.rw = 1'b0; r.jmp = 3;
            end
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = int'($urandom_range(0, 9));
        case (k)
            0: w[6:0] = 7'h33;
            1: w[6:0] = 7'h13;
            2: w[6:0] = 7'h37;
            3: w[6:0] = 7'h17;
            4: w[6:0] = 7'h03;
            5: w[6:0] = 7'h23;
            6: w[6:0] = 7'h6F;
            7: w[6:0] = 7'h67;
            8: w[6:0] = 7'h63;
            default: w[6:0] = 7'($urandom);
        endcase
        if (k <= 1 && $urandom_range(0, 3) != 0)
            w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return w;
    endfunction

    // Builds the expected cycle trace for one instruction, then drives and checks it.
    task automatic exec_instr(input logic [31:0] ins, input int iwait, input int dwait,
                              input logic z, input logic l);
        ref_t        r;
        logic [19:0] base, em, ee, obs;
        logic [1:0]  ps;
        r = ref_decode(ins);
        trace.delete();
        base = pk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, '0, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < iwait; i++)
            trace.push_back(mk(1'b0, rb(), rb(), rb(), $urandom,
                pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0), base, 0));
        trace.push_back(mk(1'b1, rb(), rb(), rb(), $urandom,
            pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0), base, 1));
        trace.push_back(mk(rb(), rb(), rb(), rb(), ins, '0, base, 2));
        if (r.ill) begin
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
            for (int i = 0; i < 3; i++)
                trace.push_back(mk(rb(), rb(), rb(), rb(), ins,
                    pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0, '0, '0, '0), base, 6));
`else
            trace.push_back(mk(rb(), rb(), rb(), rb(), ins,
                pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0, 1'b0, 1'b0, '0, '0, 2'd0),
                base | pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '1), 5));
            trace.push_back(mk(1'b0, rb(), rb(), rb(), $urandom,
                pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0), base, 7));
`endif
        end else begin
            ee = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, r.op, r.sa, r.sb, r.imm, '0, '0);
            em = base | pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {4{r.c_op}}, r.c_sa, r.c_sb,
                           {3{r.c_imm}}, '0, '0);
            trace.push_back(mk(rb(), rb(), z, l, ins, ee, em, 3));
            if (r.mem) begin
                ee = pk(1'b0, 1'b0, 1'b1, r.st, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
                em = base | pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
                for (int i = 0; i < dwait; i++)
                    trace.push_back(mk(rb(), 1'b0, rb(), rb(), ins, ee, em, 4));
                trace.push_back(mk(rb(), 1'b1, rb(), rb(), ins, ee, em, 4));
            end
            case (r.jmp)
                1:       ps = 2'd1;
                2:       ps = 2'd2;
                3:       ps = branch_taken(ins[14:12], z, l) ? 2'd1 : 2'd0;
                default: ps = 2'd0;
            endcase
            ee = pk(1'b0, 1'b0, 1'b0, 1'b0, r.rw, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, r.rs, ps);
            em = base | pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, {2{r.rw}}, '1);
            trace.push_back(mk(rb(), rb(), rb(), rb(), ins, ee, em, 5));
            trace.push_back(mk(1'b0, rb(), rb(), rb(), $urandom,
                pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0), base, 7));
        end
        foreach (trace[k]) begin
            imem_ack = trace[k].ia;
            dmem_ack = trace[k].da;
            alu_zero = trace[k].z;
            alu_lsb  = trace[k].l;
            instr    = trace[k].ins;
            @(negedge clk);
            obs = observe();
            vec++;
            if ((obs & trace[k].m) !== (trace[k].e & trace[k].m)) begin
                errs++;
                $display("FAIL %s instr=%08h cycle=%0d got=%05h want=%05h mask=%05h",
                         ph_name(trace[k].ph), ins, k, obs, trace[k].e, trace[k].m);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [19:0] obs;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem_ack = rb(); dmem_ack = rb(); alu_zero = rb(); alu_lsb = rb(); instr = $urandom;
            @(negedge clk);
            obs = observe();
            vec++;
            if (obs !== 20'h0) begin
                errs++;
                $display("FAIL reset_outputs cycle=%0d got=%05h want=00000", i, obs);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0; imem_ack = 1'b0;
        @(negedge clk);
        obs = observe();
        vec++;
        if (obs !== pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0)) begin
            errs++;
            $display("FAIL reset_release got=%05h want=80000", obs);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        exec_instr(32'h002081B3, 0, 0, 1'b0, 1'b0);  // ADD
        exec_instr(32'h4032D293, 1, 0, 1'b0, 1'b0);  // SRAI
        exec_instr(32'h0032D293, 0, 0, 1'b1, 1'b1);  // SRLI
        exec_instr(32'h0080A203, 0, 3, 1'b0, 1'b0);  // LW, dmem_ack after 3 waits
        exec_instr(32'h0020C463, 0, 0, 1'b0, 1'b1);  // BLT taken
        exec_instr(32'h0020C463, 2, 0, 1'b1, 1'b0);  // BLT not taken
        exec_instr(32'h0020A423, 0, 1, 1'b0, 1'b0);  // SW
        exec_instr(32'h008000EF, 0, 0, 1'b0, 1'b0);  // JAL
        exec_instr(32'h000080E7, 0, 0, 1'b0, 1'b0);  // JALR
        exec_instr(32'h00208463, 0, 0, 1'b1, 1'b0);  // BEQ taken
        exec_instr(32'h123450B7, 0, 0, 1'b0, 1'b0);  // LUI
        exec_instr(32'h00001097, 0, 0, 1'b0, 1'b0);  // AUIPC
    endtask

    task automatic test_illegal();
        logic [31:0] bad [5];
        logic [19:0] obs;
        bad[0] = 32'h0000007F;  // unknown opcode
        bad[1] = 32'h022081B3;  // R-type funct7 0x01
        bad[2] = 32'h02009093;  // SLLI funct7 != 0
        bad[3] = 32'h2032D293;  // shift-right funct7 0x10
        bad[4] = 32'h0020A463;  // branch funct3 010
        for (int i = 0; i < 5; i++) begin
            exec_instr(bad[i], int'($urandom_range(0, 2)), 0, rb(), rb());
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
            rst = 1'b1;
            @(negedge clk);
            obs = observe();
            vec++;
            if (obs !== 20'h0) begin
                errs++;
                $display("FAIL trap_reset got=%05h want=00000", obs);
            end
            @(posedge clk); #1;
            rst = 1'b0; imem_ack = 1'b0;
            @(negedge clk);
            obs = observe();
            vec++;
            if (obs !== pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0)) begin
                errs++;
                $display("FAIL trap_release got=%05h want=80000", obs);
            end
            @(posedge clk); #1;
`endif
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] obs;
        logic [19:0] fetch_only;
        fetch_only = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        instr = 32'h0080A203; dmem_ack = 1'b0;
        imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        vec++;
        if (dmem_req !== 1'b1) begin
            errs++;
            $display("FAIL mem_before_reset dmem_req=%b want=1", dmem_req);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        obs = observe();
        vec++;
        if (obs !== 20'h0) begin
            errs++;
            $display("FAIL reset_in_mem got=%05h want=00000", obs);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            obs = observe();
            vec++;
            if (obs !== fetch_only) begin
                errs++;
                $display("FAIL after_mem_abort cycle=%0d got=%05h want=%05h", i, obs, fetch_only);
            end
            @(posedge clk); #1;
        end
        // Abort an ALU instruction in EXEC: writeback must never appear.
        instr = 32'h002081B3; imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            obs = observe();
            vec++;
            if (obs !== fetch_only) begin
                errs++;
                $display("FAIL after_exec_abort cycle=%0d got=%05h want=%05h", i, obs, fetch_only);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        ref_t        r;
        for (int n = 0; n < 300; n++) begin
            w = rand_instr();
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
            r = ref_decode(w);
            while (r.ill) begin
                w = rand_instr();
                r = ref_decode(w);
            end
`endif
            exec_instr(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rb(), rb());
        end
    endtask

    initial begin
        rst = 1'b1; instr = '0; imem_ack = 1'b0; dmem_ack = 1'b0; alu_zero = 1'b0; alu_lsb = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_reset_mid();
        test_illegal();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
